sram_frame_arbiter: RTL and testbench

//  Shares the single off-chip 16-bit SRAM between the VGA pixel-fetch reader and the frame-update writer.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_frame_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_frame_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM frame arbiter.
package sram_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_CAP,
      ST_WR_DRV,
      ST_WR_REL
   } arb_state_e;

   localparam int DEF_ADDR_W = 20;
   localparam int DEF_DATA_W = 16;
   localparam int BYTE_LANES = DEF_DATA_W / 8;

endpackage

// File: rtl/sram_frame_arbiter.sv
// Arbitrates the single async SRAM between the VGA reader and the frame writer.
// Every access is a 2-cycle drive/capture pair; arbitration chains accesses with no idle gap.
module sram_frame_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int WR_STARVE_MAX = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_ack,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [1:0]        i_wr_mask,
   output logic              o_wr_ack,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N
);

   localparam int CNT_W = $clog2(WR_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(WR_STARVE_MAX);

   arb_state_e        state;
   logic [CNT_W-1:0]  starve_cnt;
   logic [DATA_W-1:0] dq_out;
   logic              dq_oe;
   logic              arb_slot;
   logic              grant_wr;
   logic              grant_rd;

   assign io_SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

   // Only the cycle that closes an access (or idle) may start the next one.
   always_comb begin
      arb_slot = (state == ST_IDLE) || (state == ST_RD_CAP) || (state == ST_WR_REL);
      grant_wr = arb_slot && i_wr_req && (!i_rd_req || (starve_cnt == STARVE_LIM));
      grant_rd = arb_slot && !grant_wr && i_rd_req;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         starve_cnt  <= '0;
         o_rd_ack    <= 1'b0;
         o_wr_ack    <= 1'b0;
         o_rd_valid  <= 1'b0;
         o_rd_data   <= '0;
         o_busy      <= 1'b0;
         o_SRAM_ADDR <= '0;
         o_SRAM_CE_N <= 1'b1;
         o_SRAM_OE_N <= 1'b1;
         o_SRAM_WE_N <= 1'b1;
         o_SRAM_LB_N <= 1'b1;
         o_SRAM_UB_N <= 1'b1;
         dq_out      <= '0;
         dq_oe       <= 1'b0;
      end else begin
         o_rd_ack   <= 1'b0;
         o_wr_ack   <= 1'b0;
         o_rd_valid <= 1'b0;

         if (state == ST_RD_CAP) begin
            o_rd_data  <= io_SRAM_DQ;
            o_rd_valid <= 1'b1;
         end

         // Reads only count against the writer while it is actually waiting.
         if (!i_wr_req || grant_wr)
            starve_cnt <= '0;
         else if (grant_rd && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;

         case (state)
            ST_RD_ADDR: state <= ST_RD_CAP;
            ST_WR_DRV: begin
               state       <= ST_WR_REL;
               o_SRAM_WE_N <= 1'b1;
            end
            default: begin
               if (grant_wr) begin
                  state       <= ST_WR_DRV;
                  o_wr_ack    <= 1'b1;
                  o_busy      <= 1'b1;
                  o_SRAM_ADDR <= i_wr_addr;
                  dq_out      <= i_wr_data;
                  dq_oe       <= 1'b1;
                  o_SRAM_CE_N <= 1'b0;
                  o_SRAM_OE_N <= 1'b1;
                  o_SRAM_WE_N <= 1'b0;
                  o_SRAM_LB_N <= ~i_wr_mask[0];
                  o_SRAM_UB_N <= ~i_wr_mask[1];
               end else if (grant_rd) begin
                  state       <= ST_RD_ADDR;
                  o_rd_ack    <= 1'b1;
                  o_busy      <= 1'b1;
                  o_SRAM_ADDR <= i_rd_addr;
                  dq_oe       <= 1'b0;
                  o_SRAM_CE_N <= 1'b0;
                  o_SRAM_OE_N <= 1'b0;
                  o_SRAM_WE_N <= 1'b1;
                  o_SRAM_LB_N <= 1'b0;
                  o_SRAM_UB_N <= 1'b0;
               end else begin
                  state       <= ST_IDLE;
                  o_busy      <= 1'b0;
                  dq_oe       <= 1'b0;
                  o_SRAM_CE_N <= 1'b1;
                  o_SRAM_OE_N <= 1'b1;
                  o_SRAM_WE_N <= 1'b1;
                  o_SRAM_LB_N <= 1'b1;
                  o_SRAM_UB_N <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Randomized bench for sram_frame_arbiter: SRAM pin model, shadow memory and read scoreboard.
module tb_sram_frame_arbiter;

   localparam int AW  = 20;
   localparam int DW  = 16;
   localparam int MAX = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    wr_mask;
   logic          wr_ack;
   logic          busy;
   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] dq;
   logic          ce_n, oe_n, we_n, lb_n, ub_n;

   sram_frame_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_STARVE_MAX(MAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack),
      .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_wr_mask(wr_mask), .o_wr_ack(wr_ack), .o_busy(busy),
      .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(dq),
      .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
      .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            c;
   } rd_exp_t;

   rd_exp_t       rq[$];
   logic [DW-1:0] pmem [0:1023];
   logic [DW-1:0] smem [0:1023];
   int            cyc    = 0;
   int            checks = 0;
   int            errors = 0;

   function automatic logic [DW-1:0] init_val(input int i);
      logic [DW-1:0] v;
      v = 16'(i * 40503) ^ 16'h5A5A;
      if (i == 16) v = 16'hBEEF;
      return v;
   endfunction

   // SRAM pin model: drives reads combinationally, commits writes mid-cycle.
   logic mdrv;
   assign mdrv = !ce_n && !oe_n && we_n;
   assign dq   = mdrv ? pmem[sram_addr[9:0]] : 16'bz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      for (int i = 0; i < 1024; i++) pmem[i] = init_val(i);
      forever begin
         @(negedge clk);
         chk("oe_we_exclusive", {31'd0, !oe_n && !we_n}, 32'd0);
         if (rst_n && !ce_n && !we_n) begin
            if (!lb_n) pmem[sram_addr[9:0]][7:0]  = dq[7:0];
            if (!ub_n) pmem[sram_addr[9:0]][15:8] = dq[15:8];
         end
      end
   end

   // Read monitor: every valid must match the oldest accepted read.
   initial forever begin
      rd_exp_t e;
      @(negedge clk);
      if (rd_valid) begin
         if (rq.size() == 0) begin
            chk("rd_valid_unexpected", 32'd1, 32'd0);
         end else begin
            e = rq.pop_front();
            chk("rd_data", {16'd0, rd_data}, {16'd0, e.d});
            chk("rd_ack_to_valid", cyc, e.c + 2);
         end
      end
   end

   task automatic rd(input logic [AW-1:0] a, output int ack_cyc);
      bit got = 0;
      rd_req  = 1'b1;
      rd_addr = a;
      ack_cyc = -1;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (rd_ack) got = 1;
      end
      rd_req = 1'b0;
      if (!got) begin
         chk("rd_ack_timeout", 32'd0, 32'd1);
         return;
      end
      ack_cyc = cyc;
      rq.push_back('{a: a, d: smem[a[9:0]], c: cyc});
      chk("rd_addr_pins", {12'd0, sram_addr}, {12'd0, a});
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m,
                     output int ack_cyc);
      bit got = 0;
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_mask = m;
      ack_cyc = -1;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (wr_ack) got = 1;
      end
      wr_req = 1'b0;
      if (!got) begin
         chk("wr_ack_timeout", 32'd0, 32'd1);
         return;
      end
      ack_cyc = cyc;
      if (m[0]) smem[a[9:0]][7:0]  = d[7:0];
      if (m[1]) smem[a[9:0]][15:8] = d[15:8];
      chk("wr_drv_ctl", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, {27'd0, 1'b0, 1'b1, 1'b0, ~m[0], ~m[1]});
      chk("wr_drv_dq", {16'd0, dq}, {16'd0, d});
      chk("wr_drv_addr", {12'd0, sram_addr}, {12'd0, a});
      @(negedge clk);
      chk("wr_rel_ctl", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, {27'd0, 1'b0, 1'b1, 1'b1, ~m[0], ~m[1]});
      chk("wr_rel_dq", {16'd0, dq}, {16'd0, d});
      chk("wr_rel_addr", {12'd0, sram_addr}, {12'd0, a});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int            c, c0, wc, nbefore, first_after;
      int            bb [4];
      int            rc [$];
      logic [DW-1:0] old;

      for (int i = 0; i < 1024; i++) smem[i] = init_val(i);
      rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
      repeat (2) @(negedge clk);
      chk("rst_pulses", {29'd0, rd_ack, wr_ack, rd_valid}, 32'd0);
      chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_addr", {12'd0, sram_addr}, 32'd0);
      chk("rst_ctl", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1f);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single read of a known word
      c0 = cyc;
      rd(20'h00010, c);
      chk("rd_grant_to_ack", c - c0, 32'd1);
      chk("rd_ack_ctl", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, {27'd0, 5'b00100});
      chk("rd_busy", {31'd0, busy}, 32'd1);
      repeat (4) @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // lower-byte-only write
      old = pmem[32];
      wr(20'h00020, 16'hA5C3, 2'b01, c);
      @(negedge clk);
      chk("wr_lb_mem", {16'd0, pmem[32]}, {16'd0, old[15:8], 8'hC3});
      rd(20'h00020, c);
      repeat (3) @(negedge clk);

      // back-to-back reads
      for (int i = 0; i < 4; i++) rd(20'h00030 + 20'(i), bb[i]);
      for (int i = 1; i < 4; i++) chk("b2b_ack_spacing", bb[i] - bb[i-1], 32'd2);
      repeat (4) @(negedge clk);

      // empty-mask write leaves memory untouched
      old = pmem[33];
      wr(20'h00021, 16'hFFFF, 2'b00, c);
      @(negedge clk);
      chk("wr_mask0_mem", {16'd0, pmem[33]}, {16'd0, old});
      repeat (2) @(negedge clk);

      // continuous reads versus one waiting write
      rc.delete();
      fork
         begin
            for (int i = 0; i < 11; i++) begin
               rd(20'($urandom_range(0, 63)), c);
               rc.push_back(c);
            end
         end
         wr(20'($urandom_range(0, 63)), 16'($urandom), 2'b11, wc);
      join
      nbefore = 0;
      first_after = -1;
      foreach (rc[i]) begin
         if (rc[i] < wc) nbefore++;
         else if (first_after < 0) first_after = rc[i];
      end
      chk("starve_reads_before_write", nbefore, MAX);
      chk("starve_read_resume", first_after, wc + 2);
      repeat (4) @(negedge clk);

      // reset while the write strobe is active
      old = pmem[34];
      wr_req = 1'b1; wr_addr = 20'h00022; wr_data = 16'h1234; wr_mask = 2'b11;
      @(posedge clk);
      #1;
      chk("rst_mid_ack", {31'd0, wr_ack}, 32'd1);
      chk("rst_mid_we_before", {31'd0, we_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", {29'd0, ce_n, we_n, oe_n}, 32'd7);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      wr_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mid_no_pulse", {29'd0, rd_ack, wr_ack, rd_valid}, 32'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mid_idle", {30'd0, busy, ce_n}, 32'd1);
      chk("rst_mid_mem", {16'd0, pmem[34]}, {16'd0, old});

      // randomized mix
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               rd(20'($urandom_range(0, 63)), c);
            end
         end
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               wr(20'($urandom_range(0, 63)), 16'($urandom), 2'($urandom), c);
            end
         end
      join
      repeat (5) @(negedge clk);
      chk("rd_queue_drained", rq.size(), 32'd0);
      for (int i = 0; i < 64; i++) chk("mem_consistent", {16'd0, pmem[i]}, {16'd0, smem[i]});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
